// File: rtl/day1_pkg.sv
// Shared constants and types for the day-1 input parser.
// ASCII codes, parser states and the packed record handed to the accumulator.
package day1_pkg;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [1:0] {
    S_OP,
    S_NUM,
    S_SKIP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] val;
  } rec_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_L) || (c == CH_R);
  endfunction

  function automatic logic is_blank(input logic [7:0] c);
    return (c == CH_LF) || (c == CH_CR) || (c == CH_SP);
  endfunction

endpackage

// File: rtl/day1_line_parser_dec_accum.sv
// Decimal accumulator: shift-add digit entry, overflow flag, digit counter.
// Outputs reflect this cycle's update so the parser can flush on in_last.
module dec_accum #(
  parameter int VAL_W      = 24,
  parameter int MAX_DIGITS = 8,
  parameter int ND_W       = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             dig_en,
  input  logic [3:0]       dig,
  output logic [VAL_W-1:0] val,
  output logic             ovf,
  output logic [ND_W-1:0]  ndig
);

  localparam int AW = VAL_W + 4;
  localparam logic [AW-1:0] MAXV = {4'b0, {VAL_W{1'b1}}};
  localparam logic [ND_W-1:0] ND_MAX = ND_W'(MAX_DIGITS);

  logic [AW-1:0]   acc_q, acc_d, sum;
  logic            ovf_q, ovf_d;
  logic [ND_W-1:0] nd_q, nd_d;

  // acc*10 + d; four guard bits keep one overflowing step visible
  assign sum = (acc_q << 3) + (acc_q << 1) + AW'(dig);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    nd_d  = nd_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
      nd_d  = '0;
    end else if (dig_en) begin
      acc_d = sum;
      ovf_d = ovf_q | (sum > MAXV) | (nd_q == ND_MAX);
      if (nd_q != ND_MAX) begin
        nd_d = nd_q + ND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      nd_q  <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      nd_q  <= nd_d;
    end
  end

  assign val  = acc_d[VAL_W-1:0];
  assign ovf  = ovf_d;
  assign ndig = nd_d;

endmodule

// File: rtl/day1_line_parser.sv
// ASCII line parser feeding the day-1 dial accumulator.
// Turns "L68\n" style lines into {op, val} records; bad lines are counted.
module day1_line_parser
  import day1_pkg::*;
#(
  parameter int VAL_W      = 24,
  parameter int MAX_DIGITS = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             data_valid,
  output logic [31:0]      data,
  output logic [31:0]      lines_out,
  output logic [ERR_W-1:0] err_count,
  output logic             done
);

  localparam int ND_W = $clog2(MAX_DIGITS + 1);

  state_t          state, state_nxt;
  logic [7:0]      op_q;
  logic            emit, err_inc, op_ld;
  logic            clr, dig_en, good;
  logic [VAL_W-1:0] val_nxt;
  logic            ovf_nxt;
  logic [ND_W-1:0] ndig_nxt;
  rec_t            rec;

  dec_accum #(
    .VAL_W     (VAL_W),
    .MAX_DIGITS(MAX_DIGITS),
    .ND_W      (ND_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .dig_en(dig_en),
    .dig   (in_byte[3:0]),
    .val   (val_nxt),
    .ovf   (ovf_nxt),
    .ndig  (ndig_nxt)
  );

  assign good = (ndig_nxt != '0) && !ovf_nxt;
  assign rec  = '{op: op_q, val: 24'(val_nxt)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    err_inc   = 1'b0;
    op_ld     = 1'b0;
    clr       = 1'b0;
    dig_en    = 1'b0;
    if (in_valid) begin
      unique case (state)
        S_OP: begin
          unique case (1'b1)
            is_op(in_byte): begin
              op_ld     = 1'b1;
              clr       = 1'b1;
              state_nxt = S_NUM;
            end
            is_blank(in_byte): ;
            default: begin
              err_inc   = 1'b1;
              state_nxt = S_SKIP;
            end
          endcase
        end
        S_NUM: begin
          unique case (1'b1)
            is_digit(in_byte): dig_en = 1'b1;
            in_byte == CH_CR: ;
            in_byte == CH_LF: begin
              emit      = good;
              err_inc   = !good;
              state_nxt = S_OP;
            end
            default: begin
              err_inc   = 1'b1;
              state_nxt = S_SKIP;
            end
          endcase
        end
        S_SKIP: begin
          if (in_byte == CH_LF) state_nxt = S_OP;
        end
        S_DONE: ;
      endcase
      // end of stream closes any line still collecting digits
      if (in_last && state != S_DONE) begin
        if (state_nxt == S_NUM) begin
          emit    = good;
          err_inc = !good;
        end
        state_nxt = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      data       <= '0;
      lines_out  <= '0;
      err_count  <= '0;
      op_q       <= '0;
    end else begin
      data_valid <= emit;
      if (emit) begin
        data      <= rec;
        lines_out <= lines_out + 32'd1;
      end
      if (err_inc && err_count != '1) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (op_ld) op_q <= in_byte;
    end
  end

  assign done = (state == S_DONE);

endmodule

// File: tb/tb_day1_line_parser.sv
// Scoreboard bench for day1_line_parser: line-level reference model,
// directed streams plus randomized line mixes.
module tb_day1_line_parser;

  typedef logic [7:0] u8;
  typedef u8 bq_t[$];

  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0;
  logic [7:0]  in_byte = 0;
  logic        in_last = 0;
  logic        data_valid;
  logic [31:0] data;
  logic [31:0] lines_out;
  logic [15:0] err_count;
  logic        done;

  day1_line_parser dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .data_valid(data_valid),
    .data      (data),
    .lines_out (lines_out),
    .err_count (err_count),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          mon_cnt = 0;
  int          exp_err;
  int          exp_lines;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  // monitor: every record pulse must match the head of the queue
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      mon_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {32'h0, data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("data", {32'h0, data}, {32'h0, exp_q.pop_front()});
      end
      chk("lines_out_live", {32'h0, lines_out}, 64'(mon_cnt));
    end
  end

  // reference: judge each whole line on its text
  function automatic void eval_line(bq_t ln);
    int     k = 0;
    int     nd = 0;
    longint v = 0;
    bit     bad = 0;
    u8      op;
    while (k < ln.size() && (ln[k] == 8'h20 || ln[k] == 8'h0d)) k++;
    if (k == ln.size()) return;
    op = ln[k];
    if (op != "L" && op != "R") begin
      exp_err++;
      return;
    end
    for (int j = k + 1; j < ln.size(); j++) begin
      if (ln[j] == 8'h0d) continue;
      if (ln[j] >= "0" && ln[j] <= "9") begin
        nd++;
        if (nd <= 8) v = v * 10 + longint'(ln[j] - "0");
      end else begin
        bad = 1;
      end
    end
    if (bad || nd == 0 || nd > 8 || v > 16777215) begin
      exp_err++;
    end else begin
      exp_q.push_back({op, 24'(v)});
      exp_lines++;
    end
  endfunction

  function automatic void model(bq_t b, int last_idx);
    bq_t ln;
    int  n = (last_idx >= 0) ? last_idx + 1 : b.size();
    for (int i = 0; i < n; i++) begin
      if (b[i] == 8'h0a) begin
        eval_line(ln);
        ln.delete();
      end else begin
        ln.push_back(b[i]);
      end
    end
    if (last_idx >= 0) eval_line(ln);
  endfunction

  function automatic bq_t s2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    in_last = 0;
    #2;
    chk("rst_data_valid", 64'(data_valid), 0);
    chk("rst_data", {32'h0, data}, 0);
    chk("rst_lines_out", {32'h0, lines_out}, 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_done", 64'(done), 0);
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    mon_cnt = 0;
  endtask

  task automatic drive_byte(u8 c, bit last, bit gaps);
    in_valid = 1;
    in_byte  = c;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_episode(bq_t b, int last_idx, string nm, bit gaps);
    do_reset();
    exp_err   = 0;
    exp_lines = 0;
    model(b, last_idx);
    for (int i = 0; i < b.size(); i++) drive_byte(b[i], i == last_idx, gaps);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_missing"}, 64'(exp_q.size()), 0);
    chk({nm, "_err"}, 64'(err_count), 64'(exp_err));
    chk({nm, "_lines"}, {32'h0, lines_out}, 64'(exp_lines));
    chk({nm, "_done"}, 64'(done), 64'(last_idx >= 0));
  endtask

  function automatic bq_t gen_line();
    bq_t   q;
    string js = "X+-a5#";
    int    r = $urandom_range(0, 9);
    u8     op = ($urandom_range(0, 1) != 0) ? "L" : "R";
    case (r)
      0, 1, 2, 3, 4: begin
        q.push_back(op);
        repeat ($urandom_range(1, 8)) q.push_back(u8'("0" + $urandom_range(0, 9)));
        if ($urandom_range(0, 4) == 0) q.push_back(8'h0d);
      end
      5: begin
        q.push_back(op);
        q.push_back(u8'("1" + $urandom_range(0, 8)));
        repeat (7) q.push_back(u8'("0" + $urandom_range(0, 9)));
      end
      6: begin
        q.push_back(op);
        repeat (9) q.push_back(u8'("0" + $urandom_range(0, 1)));
      end
      7: begin
        case ($urandom_range(0, 2))
          0: ;
          1: q.push_back(8'h0d);
          default: q.push_back(8'h20);
        endcase
      end
      8: begin
        q.push_back(js[$urandom_range(0, 5)]);
        q.push_back("1");
        q.push_back("2");
      end
      default: begin
        q.push_back(op);
        case ($urandom_range(0, 3))
          0: ;
          1: begin q.push_back(8'h20); q.push_back("4"); end
          2: begin q.push_back("-"); q.push_back("4"); end
          default: begin q.push_back("3"); q.push_back(8'h20); q.push_back("4"); end
        endcase
      end
    endcase
    q.push_back(8'h0a);
    return q;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    int  last_idx;
    int  r;

    run_episode(s2q("L68\nR5\n"), -1, "t1", 0);
    run_episode(s2q("R0\015\n\n\nL10\n"), -1, "t2", 0);
    run_episode(s2q("X12\nL\nL3\n"), -1, "t3", 0);
    run_episode(s2q("R16777215\nR16777216\n"), -1, "t4", 0);
    run_episode(s2q("L7R1\n"), 1, "t5", 0);

    do_reset();
    b = s2q("R12");
    for (int i = 0; i < b.size(); i++) drive_byte(b[i], 0, 0);
    run_episode(s2q("L1\n"), -1, "t6", 0);

    run_episode(s2q("L0000000\nR000000001\n  L42\n+5\n"), -1, "edge", 1);

    for (int e = 0; e < 40; e++) begin
      b.delete();
      repeat ($urandom_range(3, 10)) b = {b, gen_line()};
      last_idx = -1;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        last_idx = b.size() - 1;
      end else if (r < 4) begin
        void'(b.pop_back());
        last_idx = b.size() - 1;
      end
      if (last_idx >= 0) b = {b, s2q("R1\n")};
      run_episode(b, last_idx, "rand", 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
